vga_timing_gen_param: RTL and testbench

Parametrised VGA/SVGA raster timing generator. It is the successor to the fixed 640x480 controller. It generates H/V sync with programmable porches and polarity. It issues pixel requests with a programmable lead so that framebuffer/SDRAM sources of fixed latency can be used, registers RGB to the DAC, and provides built-in colour-bar and grid test patterns. It sits between the frame-buffer read port and the VGA DAC pins.

---
 rtl/vga_timing_gen_param.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_vga_timing_gen_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_param.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_param
// Brief    : Parametrised VGA/SVGA raster timing generator. Produces H/V sync
//            with programmable porches and polarity, issues pixel requests a
//            programmable number of clocks ahead of the raster so that a
//            fixed-latency source (frame buffer / SDRAM) can be used,
//            registers RGB towards the DAC and provides colour-bar and grid
//            test patterns.
// Revision : 1.0 - initial release, successor of the fixed 640x480 controller
// ============================================================================
module vga_timing_gen_param #(
  parameter int   COLOR_W  = 10,
  parameter int   CNT_W    = 12,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_ACT    = 640,
  parameter int   H_FP     = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   V_ACT    = 480,
  parameter int   V_FP     = 10,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   REQ_LEAD = 2
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [1:0]         iMode,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oRequest,
  output logic [CNT_W-1:0]   oCoord_X,
  output logic [CNT_W-1:0]   oCoord_Y,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK_N,
  output logic               oVGA_SYNC_N,
  output logic               oVGA_CLOCK,
  output logic               oFrame_Start,
  output logic               oLine_Start
);

  // --------------------------------------------------------------------------
  // Derived timing constants
  // --------------------------------------------------------------------------
  localparam int c_h_tot = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int c_v_tot = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int c_xs    = H_SYNC + H_BP;
  localparam int c_ys    = V_SYNC + V_BP;
  // The request flop adds one clock of its own, so the decision is taken
  // one position further ahead than the source latency.
  localparam int c_lead  = REQ_LEAD + 1;
  localparam int c_bw    = H_ACT / 8;

  localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(c_h_tot - 1);
  localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(c_v_tot - 1);
  localparam logic [CNT_W-1:0] c_h_sync_e = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] c_v_sync_e = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] c_xs_w     = CNT_W'(c_xs);
  localparam logic [CNT_W-1:0] c_xe_w     = CNT_W'(c_xs + H_ACT);
  localparam logic [CNT_W-1:0] c_ys_w     = CNT_W'(c_ys);
  localparam logic [CNT_W-1:0] c_ye_w     = CNT_W'(c_ys + V_ACT);
  localparam logic [CNT_W-1:0] c_rs_w     = CNT_W'(c_xs - c_lead);
  localparam logic [CNT_W-1:0] c_re_w     = CNT_W'(c_xs + H_ACT - c_lead);
  localparam logic [CNT_W-1:0] c_bw_last  = CNT_W'(c_bw - 1);
  localparam logic [3:0]       c_xs_lo    = 4'(c_xs);

  localparam logic [1:0] c_mode_bars = 2'd1;
  localparam logic [1:0] c_mode_grid = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   v_q, v_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]         bar_idx_q, bar_idx_d;

  logic               req_q, req_d;
  logic [CNT_W-1:0]   coord_x_q, coord_x_d;
  logic [CNT_W-1:0]   coord_y_q, coord_y_d;
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               blank_n_q, blank_n_d;
  logic               frame_q, frame_d;
  logic               line_q, line_d;

  // --------------------------------------------------------------------------
  // Region decode from the raster counters
  // --------------------------------------------------------------------------
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_act;
  logic             w_req_h;
  logic             w_origin;
  logic             w_pass;
  logic [CNT_W-1:0] w_y;
  logic [CNT_W-1:0] w_rx;
  logic [3:0]       w_x_lo;
  logic             w_grid;
  logic             w_bar_r;
  logic             w_bar_g;
  logic             w_bar_b;

  assign w_h_sync = (h_q < c_h_sync_e);
  assign w_v_sync = (v_q < c_v_sync_e);
  assign w_h_act  = (h_q >= c_xs_w) && (h_q < c_xe_w);
  assign w_v_act  = (v_q >= c_ys_w) && (v_q < c_ye_w);
  assign w_act    = w_h_act && w_v_act;
  // Request window is the active window shifted left by the lead.
  assign w_req_h  = (h_q >= c_rs_w) && (h_q < c_re_w);
  assign w_origin = (h_q == '0) && (v_q == '0);
  assign w_pass   = (mode_q != c_mode_bars) && (mode_q != c_mode_grid);

  assign w_y      = v_q - c_ys_w;
  assign w_rx     = h_q - c_rs_w;
  // Only the low nibble of the pixel column matters for the grid.
  assign w_x_lo   = h_q[3:0] - c_xs_lo;
  assign w_grid   = (w_x_lo == 4'd0) || (w_y[3:0] == 4'd0);

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps
  // onto inverted index bits: R = ~idx[1], G = ~idx[2], B = ~idx[0].
  assign w_bar_r  = ~bar_idx_q[1];
  assign w_bar_g  = ~bar_idx_q[2];
  assign w_bar_b  = ~bar_idx_q[0];

  // Raster counters: H wraps at the line end, V steps only on the H wrap.
  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (h_q == c_h_last) begin
      h_d = '0;
      if (v_q == c_v_last) begin
        v_d = '0;
      end else begin
        v_d = v_q + CNT_W'(1);
      end
    end
  end

  // Mode is captured only at the frame origin so a frame never mixes modes.
  always_comb begin
    mode_d = mode_q;
    if (w_origin) begin
      mode_d = iMode;
    end
  end

  // Bar position tracked with a width counter instead of dividing the column.
  always_comb begin
    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (w_h_act) begin
      if (bar_cnt_q == c_bw_last) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + CNT_W'(1);
        bar_idx_d = bar_idx_q;
      end
    end
  end

  // Pixel requests lead the raster; coordinates hold while idle.
  always_comb begin
    req_d     = w_req_h && w_v_act && w_pass;
    coord_x_d = coord_x_q;
    coord_y_d = coord_y_q;
    if (req_d) begin
      coord_x_d = w_rx;
      coord_y_d = w_y;
    end
  end

  // DAC-side data: pattern or pass-through inside the active area, else 0.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (w_act) begin
      case (mode_q)
        c_mode_bars: begin
          red_d   = {COLOR_W{w_bar_r}};
          green_d = {COLOR_W{w_bar_g}};
          blue_d  = {COLOR_W{w_bar_b}};
        end
        c_mode_grid: begin
          red_d   = {COLOR_W{w_grid}};
          green_d = {COLOR_W{w_grid}};
          blue_d  = {COLOR_W{w_grid}};
        end
        default: begin
          red_d   = iRed;
          green_d = iGreen;
          blue_d  = iBlue;
        end
      endcase
    end
  end

  // Sync, blank and marker pulses, aligned with the RGB register.
  always_comb begin
    hsync_d   = w_h_sync ? H_POL : ~H_POL;
    vsync_d   = w_v_sync ? V_POL : ~V_POL;
    blank_n_d = w_act;
    line_d    = (h_q == '0);
    frame_d   = w_origin;
  end

  // Raster and pattern state registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      h_q       <= '0;
      v_q       <= '0;
      mode_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      mode_q    <= mode_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Output registers towards the source and the DAC.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      req_q     <= 1'b0;
      coord_x_q <= '0;
      coord_y_q <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      hsync_q   <= ~H_POL;
      vsync_q   <= ~V_POL;
      blank_n_q <= 1'b0;
      frame_q   <= 1'b0;
      line_q    <= 1'b0;
    end else begin
      req_q     <= req_d;
      coord_x_q <= coord_x_d;
      coord_y_q <= coord_y_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      frame_q   <= frame_d;
      line_q    <= line_d;
    end
  end

  assign oRequest     = req_q;
  assign oCoord_X     = coord_x_q;
  assign oCoord_Y     = coord_y_q;
  assign oVGA_R       = red_q;
  assign oVGA_G       = green_q;
  assign oVGA_B       = blue_q;
  assign oVGA_H_SYNC  = hsync_q;
  assign oVGA_V_SYNC  = vsync_q;
  assign oVGA_BLANK_N = blank_n_q;
  assign oFrame_Start = frame_q;
  assign oLine_Start  = line_q;
  // Composite sync on the DAC is unused; the pixel clock is forwarded as is.
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_CLOCK   = iCLK;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen_param
// Brief    : Directed bench for vga_timing_gen_param on a small 28x14 raster
//            (H 4/4/16/4, V 2/2/8/2, lead 2). A second instance built with
//            inverted sync polarity runs alongside.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen_param;

  localparam int CW = 10;
  localparam int NW = 12;
  localparam int HT = 28;
  localparam int VT = 14;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    mode;
  logic [CW-1:0] in_r, in_g, in_b;

  logic          req_o;
  logic [NW-1:0] coord_x, coord_y;
  logic [CW-1:0] o_r, o_g, o_b;
  logic          o_hs, o_vs, o_blank_n, o_sync_n, o_clk, o_fs, o_ls;

  logic          p_req;
  logic [NW-1:0] p_cx, p_cy;
  logic [CW-1:0] p_r, p_g, p_b;
  logic          p_hs, p_vs, p_blank_n, p_sync_n, p_clk, p_fs, p_ls;

  int n_checks = 0;
  int n_errors = 0;

  // Colour bar RGB bits, white .. black.
  logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                              3'b101, 3'b100, 3'b001, 3'b000};

  // Fixed 2-clock-latency source returning the requested column.
  logic [CW-1:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= coord_x[CW-1:0];
    pipe2 <= pipe1;
  end
  assign in_r = pipe2;
  assign in_g = pipe2 + 10'd100;
  assign in_b = 10'd1023 - pipe2;

  vga_timing_gen_param #(
    .COLOR_W(CW), .CNT_W(NW),
    .H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4),
    .V_SYNC(2), .V_BP(2), .V_ACT(8), .V_FP(2),
    .H_POL(1'b0), .V_POL(1'b0), .REQ_LEAD(2)
  ) u_dut (
    .iCLK(clk), .iRST(rst), .iMode(mode),
    .iRed(in_r), .iGreen(in_g), .iBlue(in_b),
    .oRequest(req_o), .oCoord_X(coord_x), .oCoord_Y(coord_y),
    .oVGA_R(o_r), .oVGA_G(o_g), .oVGA_B(o_b),
    .oVGA_H_SYNC(o_hs), .oVGA_V_SYNC(o_vs), .oVGA_BLANK_N(o_blank_n),
    .oVGA_SYNC_N(o_sync_n), .oVGA_CLOCK(o_clk),
    .oFrame_Start(o_fs), .oLine_Start(o_ls)
  );

  vga_timing_gen_param #(
    .COLOR_W(CW), .CNT_W(NW),
    .H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4),
    .V_SYNC(2), .V_BP(2), .V_ACT(8), .V_FP(2),
    .H_POL(1'b1), .V_POL(1'b1), .REQ_LEAD(2)
  ) u_pol (
    .iCLK(clk), .iRST(rst), .iMode(mode),
    .iRed(in_r), .iGreen(in_g), .iBlue(in_b),
    .oRequest(p_req), .oCoord_X(p_cx), .oCoord_Y(p_cy),
    .oVGA_R(p_r), .oVGA_G(p_g), .oVGA_B(p_b),
    .oVGA_H_SYNC(p_hs), .oVGA_V_SYNC(p_vs), .oVGA_BLANK_N(p_blank_n),
    .oVGA_SYNC_N(p_sync_n), .oVGA_CLOCK(p_clk),
    .oFrame_Start(p_fs), .oLine_Start(p_ls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Sample k of a frame shows counter state h = k%28, v = k/28.
  task automatic check_sample(input int k, input int m);
    int h, v, x, y;
    bit act, req, white;
    logic [2:0] c;
    logic [31:0] er, eg, eb;
    h = k % HT;
    v = k / HT;
    x = h - 8;
    y = v - 4;
    act = (h >= 8) && (h < 24) && (v >= 4) && (v < 12);
    req = ((m == 0) || (m == 3)) && (v >= 4) && (v < 12) && (h >= 5) && (h < 21);
    chk("hsync",       o_hs,      (h < 4) ? 0 : 1);
    chk("vsync",       o_vs,      (v < 2) ? 0 : 1);
    chk("hsync_pol",   p_hs,      (h < 4) ? 1 : 0);
    chk("vsync_pol",   p_vs,      (v < 2) ? 1 : 0);
    chk("blank_n",     o_blank_n, act ? 1 : 0);
    chk("line_start",  o_ls,      (h == 0) ? 1 : 0);
    chk("frame_start", o_fs,      (k == 0) ? 1 : 0);
    chk("sync_n",      o_sync_n,  0);
    if (!act) begin
      er = 0; eg = 0; eb = 0;
    end else if (m == 1) begin
      c  = bar_tab[x / 2];
      er = c[2] ? 1023 : 0;
      eg = c[1] ? 1023 : 0;
      eb = c[0] ? 1023 : 0;
    end else if (m == 2) begin
      white = ((x % 16) == 0) || ((y % 16) == 0);
      er = white ? 1023 : 0;
      eg = er;
      eb = er;
    end else begin
      er = x;
      eg = x + 100;
      eb = 1023 - x;
    end
    chk("red",     o_r,   er);
    chk("green",   o_g,   eg);
    chk("blue",    o_b,   eb);
    chk("request", req_o, req ? 1 : 0);
    if (req) begin
      chk("coord_x", coord_x, h - 5);
      chk("coord_y", coord_y, v - 4);
    end
  endtask

  // Runs one frame expecting mode m; optionally changes iMode after sample
  // sw_at, or stops after sample stop_at (leaving the frame unfinished).
  task automatic run_frame(input int m, input int sw_at, input logic [1:0] sw_mode,
                           input int stop_at);
    int line_req [VT];
    int tot, fx, fy, lx, ly;
    bit pass;
    tot = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    for (int i = 0; i < VT; i++) line_req[i] = 0;
    for (int k = 0; k < FT; k++) begin
      @(negedge clk);
      check_sample(k, m);
      if (req_o === 1'b1) begin
        line_req[k / HT]++;
        tot++;
        if (tot == 1) begin
          fx = int'(coord_x);
          fy = int'(coord_y);
        end
        lx = int'(coord_x);
        ly = int'(coord_y);
      end
      if (k == sw_at) mode = sw_mode;
      if (k == stop_at) return;
    end
    pass = (m == 0) || (m == 3);
    for (int i = 0; i < VT; i++)
      chk("line_requests", line_req[i], (pass && i >= 4 && i < 12) ? 16 : 0);
    chk("frame_requests", tot, pass ? 128 : 0);
    if (pass) begin
      chk("first_req_x", fx, 0);
      chk("first_req_y", fy, 0);
      chk("last_req_x",  lx, 15);
      chk("last_req_y",  ly, 7);
    end
    chk("coord_x_hold", coord_x, 15);
    chk("coord_y_hold", coord_y, 7);
  endtask

  // Holds reset for three edges, checking reset values after each.
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_request", req_o,     0);
      chk("rst_coord_x", coord_x,   0);
      chk("rst_coord_y", coord_y,   0);
      chk("rst_red",     o_r,       0);
      chk("rst_green",   o_g,       0);
      chk("rst_blue",    o_b,       0);
      chk("rst_blank_n", o_blank_n, 0);
      chk("rst_frame",   o_fs,      0);
      chk("rst_line",    o_ls,      0);
      chk("rst_hsync",   o_hs,      1);
      chk("rst_vsync",   o_vs,      1);
      chk("rst_hs_pol",  p_hs,      0);
      chk("rst_vs_pol",  p_vs,      0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    mode = 2'd0;
    do_reset();
    // Pass-through; switch to bars mid-frame, must stay pass-through here.
    run_frame(0, 200, 2'd1, -1);
    // Bars; switch to grid mid-frame.
    run_frame(1, 100, 2'd2, -1);
    // Grid; switch to mode 3.
    run_frame(2, 300, 2'd3, -1);
    // Mode 3 behaves as pass-through; reset lands at H=10 of line 6.
    run_frame(3, -1, 2'd0, 6 * HT + 10);
    do_reset();
    // Restart from the origin with identical timing; iMode is still 3.
    run_frame(3, -1, 2'd0, -1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
